// File: rtl/morse_decoder_pkg.sv
// Shared types and constants for the Morse decoder path.
//   sym_t   : symbol token delivered by morse_timing_classifier
//   state_t : classifier period tracker (idle / key pressed / key released)
//   *_UNITS_C : threshold multipliers applied to the dot unit in unit mode
//   *_TICKS_C : fixed-mode tick thresholds (default parameter values)
package morse_decoder_pkg;

  typedef enum logic [2:0] {
    SYM_DOT      = 3'd0,
    SYM_DASH     = 3'd1,
    SYM_ILLEGAL  = 3'd2,
    SYM_CHAR_GAP = 3'd3,
    SYM_WORD_GAP = 3'd4
  } sym_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int unsigned DASH_UNITS_C    = 2;
  localparam int unsigned ILLEGAL_UNITS_C = 5;
  localparam int unsigned INTER_UNITS_C   = 2;
  localparam int unsigned WORD_UNITS_C    = 5;

  localparam int unsigned DASH_TICKS_C    = 30_000_000;
  localparam int unsigned ILLEGAL_TICKS_C = 100_000_000;
  localparam int unsigned INTER_TICKS_C   = 175_000_000;
  localparam int unsigned WORD_TICKS_C    = 250_000_000;

endpackage

// File: rtl/morse_threshold_gen.sv
// Threshold set for the timing classifier.
// mode/unit are captured when latch_en pulses (entry into a press or gap
// period) so a mid-period change cannot move the goal posts. Thresholds
// are then derived combinationally, CNT_W+3 bits wide so 5*unit never wraps.
//   clk, rst        : clock, synchronous active-high reset
//   latch_en        : capture mode_i / unit_ticks_i this cycle
//   mode_i          : 0 = fixed tick parameters, 1 = unit-scaled
//   unit_ticks_i    : dot-unit length in ticks (0 treated as 1)
//   dash_th .. word_th : active thresholds
module morse_threshold_gen
  import morse_decoder_pkg::*;
#(
  parameter int          CNT_W         = 28,
  parameter int unsigned DASH_TICKS    = DASH_TICKS_C,
  parameter int unsigned ILLEGAL_TICKS = ILLEGAL_TICKS_C,
  parameter int unsigned INTER_TICKS   = INTER_TICKS_C,
  parameter int unsigned WORD_TICKS    = WORD_TICKS_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch_en,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] unit_ticks_i,
  output logic [CNT_W+2:0] dash_th,
  output logic [CNT_W+2:0] illegal_th,
  output logic [CNT_W+2:0] inter_th,
  output logic [CNT_W+2:0] word_th
);

  localparam int TW = CNT_W + 3;

  logic             mode_q;
  logic [CNT_W-1:0] unit_q;
  logic [TW-1:0]    u;

  // Shift/add multiply by a small constant (multipliers fit in 3 bits).
  function automatic logic [TW-1:0] scale(input logic [TW-1:0] base,
                                          input int unsigned units);
    logic [TW-1:0] acc;
    acc = '0;
    for (int b = 0; b < 3; b++)
      if (units[b]) acc = acc + (base << b);
    return acc;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      unit_q <= '0;
    end else if (latch_en) begin
      mode_q <= mode_i;
      unit_q <= unit_ticks_i;
    end
  end

  assign u = (unit_q == '0) ? TW'(1) : TW'(unit_q);

  always_comb begin
    if (mode_q) begin
      dash_th    = scale(u, DASH_UNITS_C);
      illegal_th = scale(u, ILLEGAL_UNITS_C);
      inter_th   = scale(u, INTER_UNITS_C);
      word_th    = scale(u, WORD_UNITS_C);
    end else begin
      dash_th    = TW'(DASH_TICKS);
      illegal_th = TW'(ILLEGAL_TICKS);
      inter_th   = TW'(INTER_TICKS);
      word_th    = TW'(WORD_TICKS);
    end
  end

endmodule

// File: rtl/morse_timing_classifier.sv
// Morse key timing classifier.
// Measures press and idle durations of the debounced key and turns them
// into DOT / DASH / ILLEGAL / CHAR_GAP / WORD_GAP tokens on a single-entry
// valid/ready register.
//   clk, rst     : clock, synchronous active-high reset
//   key_i        : debounced key level, 1 = pressed
//   mode_i       : 0 = fixed thresholds, 1 = unit-scaled thresholds
//   unit_ticks_i : dot-unit length in ticks
//   sym_valid_o / sym_o / sym_ready_i : token handshake
//   overflow_o   : sticky, a token was dropped under backpressure
module morse_timing_classifier
  import morse_decoder_pkg::*;
#(
  parameter int          CNT_W         = 28,
  parameter int unsigned DASH_TICKS    = DASH_TICKS_C,
  parameter int unsigned ILLEGAL_TICKS = ILLEGAL_TICKS_C,
  parameter int unsigned INTER_TICKS   = INTER_TICKS_C,
  parameter int unsigned WORD_TICKS    = WORD_TICKS_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] unit_ticks_i,
  output logic             sym_valid_o,
  output logic [2:0]       sym_o,
  input  logic             sym_ready_i,
  output logic             overflow_o
);

  localparam int TW = CNT_W + 3;

  if (DASH_TICKS >= ILLEGAL_TICKS) begin : g_bad_dash
    $error("DASH_TICKS must be below ILLEGAL_TICKS");
  end
  if (INTER_TICKS >= WORD_TICKS) begin : g_bad_inter
    $error("INTER_TICKS must be below WORD_TICKS");
  end
  if ((64'(WORD_TICKS) >> CNT_W) != 64'd0) begin : g_bad_word
    $error("WORD_TICKS must fit in CNT_W bits");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt, cnt_sat;
  logic [TW-1:0]    cnt_x, cnt_nxt_x;
  logic [TW-1:0]    dash_th, illegal_th, inter_th, word_th;
  logic             key_q, rise, latch_en, word_hit;
  logic             tok_vld;
  sym_t             tok;

  assign rise      = key_i & ~key_q;
  assign cnt_sat   = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign cnt_x     = TW'(cnt);
  assign cnt_nxt_x = cnt_x + TW'(1);
  assign word_hit  = (state == S_GAP) && !key_i && (cnt_nxt_x == word_th);

  // Capture mode/unit on every transition into S_PRESS or S_GAP.
  assign latch_en = ((state == S_IDLE || state == S_GAP) && rise) ||
                    ((state == S_PRESS) && !key_i);

  morse_threshold_gen #(
    .CNT_W(CNT_W), .DASH_TICKS(DASH_TICKS), .ILLEGAL_TICKS(ILLEGAL_TICKS),
    .INTER_TICKS(INTER_TICKS), .WORD_TICKS(WORD_TICKS)
  ) u_thr (
    .clk(clk), .rst(rst), .latch_en(latch_en), .mode_i(mode_i),
    .unit_ticks_i(unit_ticks_i), .dash_th(dash_th), .illegal_th(illegal_th),
    .inter_th(inter_th), .word_th(word_th)
  );

  always_comb begin
    tok_vld = 1'b0;
    tok     = SYM_DOT;
    case (state)
      S_PRESS: if (!key_i) begin
        tok_vld = 1'b1;
        if (cnt_x < dash_th)         tok = SYM_DOT;
        else if (cnt_x < illegal_th) tok = SYM_DASH;
        else                         tok = SYM_ILLEGAL;
      end
      S_GAP: begin
        if (rise && cnt_x >= inter_th) begin
          tok_vld = 1'b1;
          tok     = SYM_CHAR_GAP;
        end else if (word_hit) begin
          tok_vld = 1'b1;
          tok     = SYM_WORD_GAP;
        end
      end
      default: ;
    endcase
  end

  // key_q resets high so a key held through reset needs a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      key_q <= 1'b1;
    end else begin
      key_q <= key_i;
      case (state)
        S_IDLE: if (rise) begin
          state <= S_PRESS;
          cnt   <= CNT_W'(1);
        end
        S_PRESS: begin
          if (key_i) cnt <= cnt_sat;
          else begin
            state <= S_GAP;
            cnt   <= CNT_W'(1);
          end
        end
        S_GAP: begin
          if (rise) begin
            state <= S_PRESS;
            cnt   <= CNT_W'(1);
          end else if (word_hit) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_sat;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Single-entry output register; a token meeting a stalled one is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_valid_o <= 1'b0;
      sym_o       <= 3'd0;
      overflow_o  <= 1'b0;
    end else if (tok_vld) begin
      if (!sym_valid_o || sym_ready_i) begin
        sym_valid_o <= 1'b1;
        sym_o       <= tok;
      end else begin
        overflow_o <= 1'b1;
      end
    end else if (sym_ready_i) begin
      sym_valid_o <= 1'b0;
    end
  end

endmodule
